// File: rtl/perf_counter_unit_pkg.sv
// Shared types, counter index map and popcount helper for the performance-monitor unit.
package perf_counter_unit_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFrozen = 2'd2
  } perf_state_e;

  localparam int unsigned PERF_CNT_CYCLE    = 0;
  localparam int unsigned PERF_CNT_INSTR    = 1;
  localparam int unsigned PERF_CNT_MULTI    = 2;
  localparam int unsigned PERF_CNT_FULL     = 3;
  localparam int unsigned PERF_CNT_EVT_BASE = 4;

  // Issue vectors are zero-padded to 8 lanes, the widest supported configuration.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One live counter: register, adder with carry-out, and clear/enable selection.
module perf_counter_cell #(
  parameter int unsigned CNT_WIDTH = 48,
  parameter int unsigned INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [INC_WIDTH-1:0] i_inc,
  output logic [CNT_WIDTH-1:0] o_value,
  output logic                 o_carry
);

  logic [CNT_WIDTH-1:0] r_value;
  logic [CNT_WIDTH:0]   w_sum;

  assign w_sum   = {1'b0, r_value} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, i_inc};
  assign o_carry = i_enable & w_sum[CNT_WIDTH];
  assign o_value = r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_clear) begin
      r_value <= '0;
    end else if (i_enable) begin
      r_value <= w_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance-monitor unit: live counters, snapshot bank and 1-cycle read port.
// Define PERF_OVF_FREEZE_EN to freeze all counting on the first overflow.
module perf_counter_unit
  import perf_counter_unit_pkg::*;
#(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned NUM_EVENTS  = 4,
  parameter int unsigned CNT_WIDTH   = 48,
  localparam int unsigned NUM_CNT    = 4 + NUM_EVENTS,
  localparam int unsigned AW         = $clog2(NUM_CNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ISSUE_WIDTH-1:0] i_issue_valid,
  input  logic [NUM_EVENTS-1:0]  i_event_in,
  input  logic                   i_ctrl_enable,
  input  logic                   i_ctrl_clear,
  input  logic                   i_snap_req,
  output logic                   o_snap_done,
  input  logic                   i_rd_req,
  input  logic [AW-1:0]          i_rd_addr,
  output logic                   o_rd_valid,
  output logic [CNT_WIDTH-1:0]   o_rd_data,
  output logic [NUM_CNT-1:0]     o_ovf_flags,
  output logic                   o_running
);

  localparam int unsigned PW = $clog2(ISSUE_WIDTH + 1);

  perf_state_e          r_state;
  logic                 r_running;
  logic                 r_snap_done;
  logic                 r_rd_valid;
  logic [CNT_WIDTH-1:0] r_rd_data;
  logic [NUM_CNT-1:0]   r_ovf;
  logic [CNT_WIDTH-1:0] r_snap [NUM_CNT];

  logic [7:0]           w_issue_ext;
  logic [3:0]           w_popcnt;
  logic [PW-1:0]        w_instr_inc;
  logic                 w_multi;
  logic                 w_full;
  logic                 w_count_en;
  logic [CNT_WIDTH-1:0] w_live [NUM_CNT];
  logic [NUM_CNT-1:0]   w_carry;
  logic [CNT_WIDTH-1:0] w_rd_mux;

  assign w_issue_ext = 8'(i_issue_valid);
  assign w_popcnt    = popcount8(w_issue_ext);
  assign w_instr_inc = PW'(w_popcnt);
  assign w_multi     = (w_popcnt >= 4'd2);
  // A single-lane core has no meaningful full-width cycle.
  assign w_full      = (ISSUE_WIDTH > 1) && (w_popcnt == 4'(ISSUE_WIDTH));
  assign w_count_en  = (r_state == StRun);

  perf_counter_cell #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cnt_cycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_ctrl_clear),
    .i_enable (w_count_en),
    .i_inc    (1'b1),
    .o_value  (w_live[PERF_CNT_CYCLE]),
    .o_carry  (w_carry[PERF_CNT_CYCLE])
  );

  perf_counter_cell #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(PW)) u_cnt_instr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_ctrl_clear),
    .i_enable (w_count_en),
    .i_inc    (w_instr_inc),
    .o_value  (w_live[PERF_CNT_INSTR]),
    .o_carry  (w_carry[PERF_CNT_INSTR])
  );

  perf_counter_cell #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cnt_multi (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_ctrl_clear),
    .i_enable (w_count_en),
    .i_inc    (w_multi),
    .o_value  (w_live[PERF_CNT_MULTI]),
    .o_carry  (w_carry[PERF_CNT_MULTI])
  );

  perf_counter_cell #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cnt_full (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (i_ctrl_clear),
    .i_enable (w_count_en),
    .i_inc    (w_full),
    .o_value  (w_live[PERF_CNT_FULL]),
    .o_carry  (w_carry[PERF_CNT_FULL])
  );

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_evt
    perf_counter_cell #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cnt_evt (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (i_ctrl_clear),
      .i_enable (w_count_en),
      .i_inc    (i_event_in[k]),
      .o_value  (w_live[PERF_CNT_EVT_BASE + k]),
      .o_carry  (w_carry[PERF_CNT_EVT_BASE + k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_running <= 1'b0;
    end else if (i_ctrl_clear) begin
      r_state   <= i_ctrl_enable ? StRun : StIdle;
      r_running <= i_ctrl_enable;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_ctrl_enable) begin
            r_state   <= StRun;
            r_running <= 1'b1;
          end
        end
        StRun: begin
`ifdef PERF_OVF_FREEZE_EN
          if (|w_carry) begin
            r_state   <= StFrozen;
            r_running <= 1'b0;
          end else
`endif
          if (!i_ctrl_enable) begin
            r_state   <= StIdle;
            r_running <= 1'b0;
          end
        end
`ifdef PERF_OVF_FREEZE_EN
        StFrozen: begin
          r_state   <= StFrozen;
          r_running <= 1'b0;
        end
`endif
        default: begin
          r_state   <= StIdle;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else if (i_ctrl_clear) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= r_ovf | w_carry;
    end
  end

  // Snapshot captures the registered live values, so snap+clear yields the interval total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        r_snap[i] <= '0;
      end
      r_snap_done <= 1'b0;
    end else begin
      if (i_snap_req) begin
        for (int i = 0; i < NUM_CNT; i++) begin
          r_snap[i] <= w_live[i];
        end
      end
      r_snap_done <= i_snap_req;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (i_rd_addr == AW'(i)) begin
        w_rd_mux = r_snap[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= i_rd_req;
      r_rd_data  <= i_rd_req ? w_rd_mux : '0;
    end
  end

  assign o_snap_done = r_snap_done;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_ovf_flags = r_ovf;
  assign o_running   = r_running;

endmodule
